// File: rtl/alu_mc.sv
// Multi-cycle ALU with A/B source muxes, valid/ready handshake and registered outputs.
// Single-cycle ops finish at the accept edge; shifts and multiply run iteratively.
module alu_mc #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Valid,
  output logic             o_Ready,
  input  logic [3:0]       i_OpCode,
  input  logic             i_SrcASel,
  input  logic [WIDTH-1:0] i_SrcA0,
  input  logic [WIDTH-1:0] i_SrcA1,
  input  logic [1:0]       i_SrcBSel,
  input  logic [WIDTH-1:0] i_SrcB0,
  input  logic [WIDTH-1:0] i_SrcB1,
  input  logic [WIDTH-1:0] i_SrcB2,
  input  logic [WIDTH-1:0] i_SrcB3,
  output logic             o_Valid,
  output logic [WIDTH-1:0] o_Result,
  output logic             o_Zero,
  output logic             o_Illegal
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = SHAMT_W + 1;
  localparam logic [CNT_W-1:0] STEP_MAX   = CNT_W'(SHIFT_STEP);
  localparam logic [CNT_W-1:0] MUL_CYCLES = CNT_W'(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MUL} state_t;

  state_t             state_reg;
  logic [3:0]         op_reg;
  logic [WIDTH-1:0]   acc_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   result_reg;
  logic               zero_reg;
  logic               illegal_reg;
  logic               valid_reg;

  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;
  logic [WIDTH-1:0]   single_res;
  logic [CNT_W-1:0]   step_val;
  logic [WIDTH-1:0]   shift_next;
  logic [WIDTH-1:0]   mul_acc_next;

  assign a_sel    = i_SrcASel ? i_SrcA1 : i_SrcA0;
  assign shamt    = b_sel[SHAMT_W-1:0];
  assign is_shift = (i_OpCode == OP_SLL) || (i_OpCode == OP_SRL) || (i_OpCode == OP_SRA);

  always_comb begin
    b_sel = i_SrcB0;
    case (i_SrcBSel)
      2'd0:    b_sel = i_SrcB0;
      2'd1:    b_sel = i_SrcB1;
      2'd2:    b_sel = i_SrcB2;
      default: b_sel = i_SrcB3;
    endcase
  end

  // Shifts only land here with a zero shift amount, so they pass A straight through.
  always_comb begin
    single_res = '0;
    case (i_OpCode)
      OP_ADD:  single_res = a_sel + b_sel;
      OP_SUB:  single_res = a_sel - b_sel;
      OP_AND:  single_res = a_sel & b_sel;
      OP_OR:   single_res = a_sel | b_sel;
      OP_XOR:  single_res = a_sel ^ b_sel;
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(a_sel) < $signed(b_sel))};
      OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (a_sel < b_sel)};
      OP_SLL, OP_SRL, OP_SRA: single_res = a_sel;
      default: single_res = '0;
    endcase
  end

  // One pre-shifted copy per possible step size; the live step picks among them.
  logic [WIDTH-1:0] shl_tbl [SHIFT_STEP+1];
  logic [WIDTH-1:0] srl_tbl [SHIFT_STEP+1];
  logic [WIDTH-1:0] sra_tbl [SHIFT_STEP+1];

  genvar gi;
  generate
    for (gi = 0; gi <= SHIFT_STEP; gi++) begin : g_step
      assign shl_tbl[gi] = acc_reg << gi;
      assign srl_tbl[gi] = acc_reg >> gi;
      assign sra_tbl[gi] = $unsigned($signed(acc_reg) >>> gi);
    end
  endgenerate

  assign step_val = (cnt_reg > STEP_MAX) ? STEP_MAX : cnt_reg;

  always_comb begin
    shift_next = acc_reg;
    for (int k = 0; k <= SHIFT_STEP; k++) begin
      if (step_val == CNT_W'(k)) begin
        case (op_reg)
          OP_SLL:  shift_next = shl_tbl[k];
          OP_SRL:  shift_next = srl_tbl[k];
          default: shift_next = sra_tbl[k];
        endcase
      end
    end
  end

  assign mul_acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_reg   <= ST_IDLE;
      op_reg      <= '0;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      cnt_reg     <= '0;
      result_reg  <= '0;
      zero_reg    <= 1'b0;
      illegal_reg <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (i_Valid) begin
            if (is_shift && (shamt != '0)) begin
              state_reg <= ST_SHIFT;
              op_reg    <= i_OpCode;
              acc_reg   <= a_sel;
              cnt_reg   <= {1'b0, shamt};
            end else if (i_OpCode == OP_MUL) begin
              state_reg  <= ST_MUL;
              acc_reg    <= '0;
              mcand_reg  <= a_sel;
              mplier_reg <= b_sel;
              cnt_reg    <= MUL_CYCLES;
            end else begin
              result_reg  <= single_res;
              zero_reg    <= (single_res == '0);
              illegal_reg <= (i_OpCode > OP_MUL);
              valid_reg   <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          acc_reg <= shift_next;
          cnt_reg <= cnt_reg - step_val;
          if (cnt_reg == step_val) begin
            state_reg   <= ST_IDLE;
            result_reg  <= shift_next;
            zero_reg    <= (shift_next == '0);
            illegal_reg <= 1'b0;
            valid_reg   <= 1'b1;
          end
        end
        ST_MUL: begin
          acc_reg    <= mul_acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg - 1'b1;
          if (cnt_reg == CNT_W'(1)) begin
            state_reg   <= ST_IDLE;
            result_reg  <= mul_acc_next;
            zero_reg    <= (mul_acc_next == '0);
            illegal_reg <= 1'b0;
            valid_reg   <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_Ready   = (state_reg == ST_IDLE);
  assign o_Valid   = valid_reg;
  assign o_Result  = result_reg;
  assign o_Zero    = zero_reg;
  assign o_Illegal = illegal_reg;

endmodule

// File: tb/tb_alu_mc.sv
// Randomized and directed bench for alu_mc at WIDTH=32, SHIFT_STEP=1,
// checked against an arithmetic reference model of each opcode and its latency.
module tb_alu_mc;

  localparam int WIDTH = 32;
  localparam int STEP  = 1;

  logic             clk;
  logic             rst_n;
  logic             valid_in;
  logic             ready;
  logic [3:0]       opcode;
  logic             a_sel;
  logic [WIDTH-1:0] a0, a1;
  logic [1:0]       b_sel;
  logic [WIDTH-1:0] b0, b1, b2, b3;
  logic             valid_out;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] prev_result = '0;

  alu_mc #(.WIDTH(WIDTH), .SHIFT_STEP(STEP)) dut (
    .i_Clk     (clk),
    .i_Rst     (rst_n),
    .i_Valid   (valid_in),
    .o_Ready   (ready),
    .i_OpCode  (opcode),
    .i_SrcASel (a_sel),
    .i_SrcA0   (a0),
    .i_SrcA1   (a1),
    .i_SrcBSel (b_sel),
    .i_SrcB0   (b0),
    .i_SrcB1   (b1),
    .i_SrcB2   (b2),
    .i_SrcB3   (b3),
    .o_Valid   (valid_out),
    .o_Result  (result),
    .o_Zero    (zero),
    .o_Illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_result(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    int unsigned sh;
    logic [63:0] prod;
    sh = b[4:0];
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  return (a < b) ? 32'd1 : 32'd0;
      4'd7:  return a << sh;
      4'd8:  return a >> sh;
      4'd9:  return $signed(a) >>> sh;
      4'd10: begin
        prod = {32'd0, a} * {32'd0, b};
        return prod[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [WIDTH-1:0] b);
    int sh;
    sh = int'(b[4:0]);
    if (op >= 4'd7 && op <= 4'd9) return 1 + (sh + STEP - 1) / STEP;
    if (op == 4'd10) return WIDTH + 1;
    return 1;
  endfunction

  // Issue one request, optionally scrambling inputs while busy, and check the completion.
  task automatic do_op(input logic [3:0] op, input logic asel, input logic [1:0] bsel,
                       input logic [WIDTH-1:0] va0, input logic [WIDTH-1:0] va1,
                       input logic [WIDTH-1:0] vb0, input logic [WIDTH-1:0] vb1,
                       input logic [WIDTH-1:0] vb2, input logic [WIDTH-1:0] vb3,
                       input bit noise);
    logic [WIDTH-1:0] a, b, exp_r;
    int exp_lat, lat;
    a = asel ? va1 : va0;
    case (bsel)
      2'd0: b = vb0;
      2'd1: b = vb1;
      2'd2: b = vb2;
      default: b = vb3;
    endcase
    exp_r   = ref_result(op, a, b);
    exp_lat = ref_latency(op, b);
    @(negedge clk);
    check_eq("ready_idle", ready, 1);
    opcode = op; a_sel = asel; b_sel = bsel;
    a0 = va0; a1 = va1; b0 = vb0; b1 = vb1; b2 = vb2; b3 = vb3;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    lat = 1;
    while (!valid_out && lat < 100) begin
      check_eq("hold_result", result, prev_result);
      if (noise && !ready) begin
        a0 = $urandom; a1 = $urandom; b0 = $urandom; b1 = $urandom;
        b2 = $urandom; b3 = $urandom; opcode = 4'($urandom_range(0, 15));
        valid_in = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    valid_in = 1'b0;
    check_eq("valid_seen", valid_out, 1);
    check_eq("latency", lat, exp_lat);
    check_eq("result", result, exp_r);
    check_eq("zero", zero, (exp_r == '0));
    check_eq("illegal", illegal, (op > 4'd10));
    $display("op=%0d a=%08h b=%08h result=%08h exp=%08h lat=%0d", op, a, b, result, exp_r, lat);
    prev_result = exp_r;
    @(negedge clk);
    check_eq("single_pulse", valid_out, 0);
    check_eq("ready_after", ready, 1);
  endtask

  initial begin
    int vcount;
    logic [3:0] rop;
    rst_n = 1'b0; valid_in = 1'b0; opcode = '0; a_sel = 1'b0; b_sel = '0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0; b2 = '0; b3 = '0;

    // Reset held two cycles, then released.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_result", result, 0);
    check_eq("rst_zero", zero, 0);
    check_eq("rst_illegal", illegal, 0);
    check_eq("rst_valid", valid_out, 0);
    check_eq("rst_ready", ready, 1);
    vcount = 0;
    repeat (5) begin
      @(negedge clk);
      if (valid_out) vcount++;
    end
    check_eq("idle_no_valid", vcount, 0);

    // Back-to-back ADD then SUB.
    opcode = 4'd0; a_sel = 1'b0; a0 = 32'd10; b_sel = 2'd0; b0 = 32'd12; valid_in = 1'b1;
    @(negedge clk);
    check_eq("b2b_add_valid", valid_out, 1);
    check_eq("b2b_add_result", result, 22);
    check_eq("b2b_add_zero", zero, 0);
    $display("op=0 a=0000000a b=0000000c result=%08h exp=00000016 lat=1", result);
    opcode = 4'd1; a_sel = 1'b1; a1 = 32'd1; b_sel = 2'd1; b1 = 32'd1; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    check_eq("b2b_sub_valid", valid_out, 1);
    check_eq("b2b_sub_result", result, 0);
    check_eq("b2b_sub_zero", zero, 1);
    $display("op=1 a=00000001 b=00000001 result=%08h exp=00000000 lat=1", result);
    @(negedge clk);
    check_eq("b2b_end_valid", valid_out, 0);
    prev_result = '0;

    // Shifts: SRA, SRL by 4, then shift amount 0 via upper B bits.
    do_op(4'd9, 1'b0, 2'd2, 32'h8000_0000, '0, '0, '0, 32'd4, '0, 1'b0);
    do_op(4'd8, 1'b0, 2'd2, 32'h8000_0000, '0, '0, '0, 32'd4, '0, 1'b0);
    do_op(4'd9, 1'b1, 2'd3, '0, 32'h8000_0000, '0, '0, '0, 32'h20, 1'b0);

    // Multiply with noisy inputs and stray requests while busy.
    do_op(4'd10, 1'b0, 2'd0, 32'hFFFF_FFFF, '0, 32'd3, '0, '0, '0, 1'b1);

    // Reset in the middle of a multiply.
    @(negedge clk);
    opcode = 4'd10; a_sel = 1'b0; a0 = 32'h1234_5678; b_sel = 2'd0; b0 = 32'h9;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("mul_busy", ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_result", result, 0);
    check_eq("midrst_zero", zero, 0);
    check_eq("midrst_illegal", illegal, 0);
    check_eq("midrst_valid", valid_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_ready", ready, 1);
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid_out) vcount++;
    end
    check_eq("midrst_no_valid", vcount, 0);
    $display("op=10 reset mid-op valid_pulses=%0d", vcount);
    prev_result = '0;

    // Compares, reserved opcode, then a legal op clearing the illegal flag.
    do_op(4'd5, 1'b0, 2'd0, 32'hFFFF_FFFF, '0, 32'd1, '0, '0, '0, 1'b0);
    do_op(4'd6, 1'b0, 2'd0, 32'hFFFF_FFFF, '0, 32'd1, '0, '0, '0, 1'b0);
    do_op(4'd15, 1'b0, 2'd0, 32'h55, '0, 32'h66, '0, '0, '0, 1'b0);
    do_op(4'd0, 1'b0, 2'd0, 32'd5, '0, 32'd7, '0, '0, '0, 1'b0);

    // Randomized operations across every opcode.
    for (int n = 0; n < 60; n++) begin
      rop = 4'($urandom_range(0, 15));
      if (n % 7 == 0)
        do_op(4'd1, 1'b0, 2'd0, 32'hA5A5_0F0F, '0, 32'hA5A5_0F0F, '0, '0, '0, 1'b1);
      else
        do_op(rop, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU for the RiscyZigler datapath; successor to the fixed 32-bit, 4-op combinational ALU.
- Keeps the operand source muxes: A has 2 inputs, B has 4 inputs.
- Adds logic, compare, iterative shift and iterative multiply operations behind a valid/ready handshake.
- Result and zero flag are registered.
- The multi-cycle control FSM drives it like any other datapath unit.

Parameters:
- WIDTH, 32, datapath width; must be a power of 2, ≥8.
- SHIFT_STEP, 1, maximum bit positions shifted per busy cycle; power of 2, ≤WIDTH.

Ports:
- i_Clk  in  1  clock; all state updates on rising edge.
- i_Rst  in  1  asynchronous, active-low reset.
- i_Valid  in  1  request; accepted when i_Valid && o_Ready.
- o_Ready  out  1  high when the unit can accept a request.
- i_OpCode  in  4  operation select.
- i_SrcASel  in  1  selects A: 0 = i_SrcA0, 1 = i_SrcA1.
- i_SrcA0, i_SrcA1  in  WIDTH  A operands.
- i_SrcBSel  in  2  selects B from i_SrcB0..i_SrcB3.
- i_SrcB0..i_SrcB3  in  WIDTH  B operands.
- o_Valid  out  1  one-cycle pulse; o_Result is new this cycle.
- o_Result  out  WIDTH  registered result; held until the next completion.
- o_Zero  out  1  registered (o_Result == 0).
- o_Illegal  out  1  registered; set when the completed op was reserved.

Behaviour:
- Reset (i_Rst low, async):
  - o_Result=0, o_Zero=0, o_Illegal=0, o_Valid=0.
  - FSM goes to IDLE; o_Ready=1 once reset releases.
  - Reset mid-operation abandons the op; no o_Valid is produced for it.
- Operand capture: A and B are the muxed values at the accepting edge. Later input changes have no effect on an in-flight op.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT (signed, result 0/1), 6 SLTU (unsigned, result 0/1).
  - 7 SLL, 8 SRL, 9 SRA.
  - 10 MUL: low WIDTH bits of A*B; signedness irrelevant.
  - 11-15 reserved: result 0, o_Illegal=1, latency 1.
- Shift amount = B[log2(WIDTH)-1:0]; upper B bits ignored. Add/sub wrap modulo 2^WIDTH; no carry or overflow output.
- FSM states: IDLE, SHIFT, MUL.
- IDLE (o_Ready=1):
  - Accept of ops 0-6, reserved ops, or a shift with shamt=0: result registered at the accept edge. o_Valid=1 the following cycle; remain IDLE.
  - Back-to-back accepts every cycle are legal.
  - Accept of a shift with shamt>0: go to SHIFT, remaining count = shamt.
  - Accept of MUL: go to MUL, counter = WIDTH.
- SHIFT (o_Ready=0): each cycle, shift by min(SHIFT_STEP, remaining) and decrement remaining. When remaining reaches 0, register the result, pulse o_Valid next cycle, return to IDLE.
  - Latency from accept edge to o_Valid = 1 + ceil(shamt/SHIFT_STEP) cycles.
  - SRA replicates the sign bit; SRL and SLL fill with zeros.
- MUL (o_Ready=0): shift-add, one multiplier bit per cycle for exactly WIDTH cycles. No early termination.
  - Latency = WIDTH+1 cycles. o_Zero is computed on the final product.
- While busy, i_Valid is ignored and no request is queued; the requester must hold i_Valid until o_Ready is high.
- o_Valid is never high in two consecutive cycles except for back-to-back single-cycle ops.
- o_Result, o_Zero and o_Illegal change only on a completion edge; otherwise they hold.

Test Plan (WIDTH=32, SHIFT_STEP=1):
1. Reset held 2 cycles, then released → all outputs 0, o_Ready=1; no o_Valid without a request.
2. Back-to-back ops:
   - Cycle N: ADD, SrcASel=0, A0=10, SrcBSel=0, B0=12 → next cycle o_Valid=1, o_Result=22, o_Zero=0.
   - Cycle N+1: SUB, SrcASel=1 (A1=1), SrcBSel=1 (B1=1) → o_Result=0, o_Zero=1 one cycle later.
3. SRA: A=0x80000000, B=4 → o_Ready low 4 cycles, then o_Valid with o_Result=0xF8000000.
   - SRL of the same operands → 0x08000000.
   - B=0x20 (shamt 0) → o_Result=A, latency 1.
4. MUL: A=0xFFFFFFFF, B=3 → o_Valid exactly 33 cycles after accept, o_Result=0xFFFFFFFD.
   - Change A0/B0 and pulse i_Valid mid-op → result unchanged, second request not taken.
5. Start MUL, assert i_Rst low at busy cycle 10 → outputs 0 immediately, o_Ready=1 after release, no o_Valid.
6. Compares and reserved op:
   - SLT with A=0xFFFFFFFF, B=1 → 1.
   - SLTU with the same operands → 0.
   - Opcode 15 → o_Result=0, o_Zero=1, o_Illegal=1.
   - Following ADD → o_Illegal returns to 0.
